md_rx_packer: RTL
=================

Name: md_rx_packer

Overview:
Upstream feeder for the aligner's MD RX port. It takes a byte-wide valid/ready stream carrying packets delimited by a last flag. It packs the bytes into legal MD RX transfers (data, offset, size) for the aligner, starting at a configurable byte lane. It also counts transfers the aligner reports as errored.

Parameters:
ALGN_DATA_WIDTH, 32, MD data width in bits; power of two, >= 16; must match the aligner.
LANES, ALGN_DATA_WIDTH/8 (derived localparam), number of byte lanes.
OFFSET_W, $clog2(LANES) (derived localparam), offset width.
SIZE_W, $clog2(LANES)+1 (derived localparam), size width.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cfg_start_offset  in  OFFSET_W  byte lane of the first byte of each packet
s_valid  in  1  input byte valid
s_data  in  8  input byte
s_last  in  1  byte is last of packet
s_ready  out  1  packer accepts byte
md_rx_valid  out  1  MD transfer valid (to aligner)
md_rx_data  out  ALGN_DATA_WIDTH  MD data, byte k at bits [8k+7:8k]
md_rx_offset  out  OFFSET_W  first valid lane
md_rx_size  out  SIZE_W  number of valid bytes, 1..LANES
md_rx_ready  in  1  aligner accepts transfer
md_rx_err  in  1  aligner error response, qualified by md_rx_ready
err_cnt  out  8  saturating count of errored transfers
xfer_cnt  out  16  wrapping count of completed transfers
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE. s_ready=0 while reset_n=0. md_rx_valid=0, md_rx_data=0, md_rx_offset=0, md_rx_size=0, err_cnt=0, xfer_cnt=0, busy=0. Lane pointer and accumulator are cleared.
- States:
  - IDLE: s_ready=1. An accepted byte (s_valid&&s_ready) samples cfg_start_offset into base and lane pointer ptr, writes the byte to lane ptr, and goes to ACCUM. If that byte is last or ptr==LANES-1, go straight to SEND.
  - ACCUM: s_ready=1. Each accepted byte is written to lane ptr and ptr increments. Go to SEND when the byte has s_last=1 or ptr==LANES-1.
  - SEND: s_ready=0. md_rx_valid=1. md_rx_offset=base, md_rx_size=ptr_at_write-base+1, md_rx_data=accumulator. Unused lanes are 0.
    - On md_rx_valid&&md_rx_ready, xfer_cnt increments. If md_rx_err=1, err_cnt increments, saturating at 255.
    - If the packet has ended (last flag latched), go to IDLE. Otherwise go to ACCUM with base=0, ptr=0 and the accumulator cleared.
- Latency: md_rx_valid rises the cycle after the closing byte is accepted. One bubble cycle on s_ready per transfer.
- MD rules:
  - md_rx_valid, once high, stays high with data, offset and size stable until md_rx_ready=1.
  - md_rx_err is ignored when md_rx_ready=0.
  - offset+size <= LANES always holds; size is never 0.
- cfg_start_offset is sampled only on the first byte of a packet. Changes mid-packet have no effect.
- A packet starting at offset LANES-1 produces a size-1 first transfer. Continuation transfers always start at offset 0.
- s_last on a byte landing in lane LANES-1 yields exactly one transfer for that chunk, with no empty trailing transfer.
- In SEND the bench must not depend on s_valid; bytes are not taken until state leaves SEND.
- reset_n asserted in any state, including SEND with md_rx_ready low: md_rx_valid drops to 0 immediately. The partial packet is discarded and is not resumed after reset.

Test Plan:
1. offset=0; bytes 11,22,33,44 with last on 44; md_rx_ready=1 -> one transfer: data=0x44332211, offset=0, size=4; xfer_cnt=1; busy returns 0.
2. offset=2; bytes AA,BB,CC with last on CC -> transfer 1: data=0xBBAA0000, offset=2, size=2. Transfer 2: data=0x000000CC, offset=0, size=1.
3. offset=3; single byte 5A with last -> data=0x5A000000, offset=3, size=1. Then offset=1 changed mid-packet on a 6-byte packet -> first transfer offset=1, size=3; second offset=0, size=3.
4. Scenario 1 with md_rx_ready held 0 for 5 cycles -> md_rx_valid=1 and fields stable for all 6 cycles; s_ready=0; transfer completes on the 6th cycle.
5. 257 transfers with md_rx_err=1 on the handshake -> err_cnt reaches 255 and holds. md_rx_err=1 with md_rx_ready=0 -> no increment.
6. reset_n pulled low in SEND while md_rx_ready=0 -> md_rx_valid=0 in the same timestep; after release: IDLE, s_ready=1, all counters 0, the next packet is packed correctly.

Source files
------------

// File: rtl/md_rx_packer.sv
// md_rx_packer: packs a byte stream into MD RX transfers starting at a configurable lane
module md_rx_packer #(
    parameter  int ALGN_DATA_WIDTH = 32,
    localparam int LANES           = ALGN_DATA_WIDTH / 8,
    localparam int OFFSET_W        = $clog2(LANES),
    localparam int SIZE_W          = $clog2(LANES) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [OFFSET_W-1:0]        cfg_start_offset,
    input  logic                       s_valid,
    input  logic [7:0]                 s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic                       md_rx_valid,
    output logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
    output logic [OFFSET_W-1:0]        md_rx_offset,
    output logic [SIZE_W-1:0]          md_rx_size,
    input  logic                       md_rx_ready,
    input  logic                       md_rx_err,
    output logic [7:0]                 err_cnt,
    output logic [15:0]                xfer_cnt,
    output logic                       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [OFFSET_W-1:0]        base_q, base_d;
    logic [SIZE_W-1:0]          ptr_q, ptr_d;
    logic [ALGN_DATA_WIDTH-1:0] acc_q, acc_d;
    logic                       last_q, last_d;
    logic [7:0]                 err_q, err_d;
    logic [15:0]                xfer_q, xfer_d;
    logic [SIZE_W-1:0]          lane;
    logic                       send;

    // ptr_q is the next free lane, so in SEND the byte count is simply ptr_q - base_q
    assign send         = state_q == SEND;
    assign s_ready      = reset_n && !send;
    assign md_rx_valid  = send;
    assign md_rx_data   = send ? acc_q : '0;
    assign md_rx_offset = send ? base_q : '0;
    assign md_rx_size   = send ? ptr_q - SIZE_W'(base_q) : '0;
    assign err_cnt      = err_q;
    assign xfer_cnt     = xfer_q;
    assign busy         = state_q != IDLE;
    assign lane         = (state_q == IDLE) ? SIZE_W'(cfg_start_offset) : ptr_q;

    // Accept bytes into the accumulator, close a chunk on last/top lane, retire it on handshake
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        ptr_d   = ptr_q;
        acc_d   = acc_q;
        last_d  = last_q;
        err_d   = err_q;
        xfer_d  = xfer_q;
        if (s_valid && s_ready) begin
            acc_d[{lane[OFFSET_W-1:0], 3'b000} +: 8] = s_data;
            ptr_d   = lane + SIZE_W'(1);
            base_d  = (state_q == IDLE) ? cfg_start_offset : base_q;
            last_d  = s_last;
            state_d = (s_last || lane == SIZE_W'(LANES - 1)) ? SEND : ACCUM;
        end
        if (md_rx_valid && md_rx_ready) begin
            xfer_d  = xfer_q + 16'd1;
            err_d   = (md_rx_err && err_q != 8'hff) ? err_q + 8'd1 : err_q;
            state_d = last_q ? IDLE : ACCUM;
            base_d  = '0;
            ptr_d   = '0;
            acc_d   = '0;
        end
    end

    // State and counter registers; reset discards any partial packet
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            ptr_q   <= '0;
            acc_q   <= '0;
            last_q  <= 1'b0;
            err_q   <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            ptr_q   <= ptr_d;
            acc_q   <= acc_d;
            last_q  <= last_d;
            err_q   <= err_d;
            xfer_q  <= xfer_d;
        end
    end
endmodule
